// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter sharing one memory port between fetch (0) and data (1).
// One outstanding transaction; response is steered back to the requester that owns it.
//
// state | meaning
// IDLE  | no transaction; grant chosen combinationally from valids and prio
// HOLD  | request presented but not yet accepted; grant locked to owner
// WAIT  | request accepted; waiting for the memory response for owner
module mem_port_arbiter #(
  parameter int p_addr_nbits = 32,
  parameter int p_data_nbits = 32
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [p_addr_nbits-1:0] req0_addr,
  input  logic                    req0_wen,
  input  logic [p_data_nbits-1:0] req0_wdata,

  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [p_addr_nbits-1:0] req1_addr,
  input  logic                    req1_wen,
  input  logic [p_data_nbits-1:0] req1_wdata,

  output logic                    resp0_val,
  output logic [p_data_nbits-1:0] resp0_rdata,
  output logic                    resp1_val,
  output logic [p_data_nbits-1:0] resp1_rdata,

  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic [p_addr_nbits-1:0] mem_req_addr,
  output logic                    mem_req_wen,
  output logic [p_data_nbits-1:0] mem_req_wdata,

  input  logic                    mem_resp_val,
  input  logic [p_data_nbits-1:0] mem_resp_rdata,

  output logic                    sel,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;
  logic   fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    sel         = owner_q;
    mem_req_val = 1'b0;
    busy        = 1'b0;
    resp0_val   = 1'b0;
    resp1_val   = 1'b0;
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;

    // A lone valid requester wins outright; ties and no-request fall back to prio.
    if (state_q == IDLE) begin
      if (req0_val && !req1_val)      sel = 1'b0;
      else if (req1_val && !req0_val) sel = 1'b1;
      else                            sel = prio_q;
    end

    case (state_q)
      IDLE: mem_req_val = req0_val || req1_val;
      HOLD: mem_req_val = 1'b1;
      default: mem_req_val = 1'b0;
    endcase

    fire = mem_req_val && mem_req_rdy;

    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = WAIT;
          owner_d = sel;
          prio_d  = ~sel;
        end else if (req0_val || req1_val) begin
          state_d = HOLD;
          owner_d = sel;
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (fire) begin
          state_d = WAIT;
          prio_d  = ~owner_q;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (mem_resp_val) begin
          resp0_val = (owner_q == 1'b0);
          resp1_val = (owner_q == 1'b1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req0_rdy      = fire && (sel == 1'b0);
  assign req1_rdy      = fire && (sel == 1'b1);

  assign mem_req_addr  = sel ? req1_addr  : req0_addr;
  assign mem_req_wen   = sel ? req1_wen   : req0_wen;
  assign mem_req_wdata = sel ? req1_wdata : req0_wdata;

  assign resp0_rdata   = mem_resp_rdata;
  assign resp1_rdata   = mem_resp_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a directed vector table applied one cycle per row,
// plus hand-written write and reset-during-WAIT sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_val, req0_rdy, req0_wen;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_val, req1_rdy, req1_wen;
  logic [31:0] req1_addr, req1_wdata;
  logic        resp0_val, resp1_val;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic        mem_req_val, mem_req_rdy, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_val;
  logic [31:0] mem_resp_rdata;
  logic        sel, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.p_addr_nbits(32), .p_data_nbits(32)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_addr(req0_addr),
    .req0_wen(req0_wen), .req0_wdata(req0_wdata),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_addr(req1_addr),
    .req1_wen(req1_wen), .req1_wdata(req1_wdata),
    .resp0_val(resp0_val), .resp0_rdata(resp0_rdata),
    .resp1_val(resp1_val), .resp1_rdata(resp1_rdata),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
    .mem_resp_val(mem_resp_val), .mem_resp_rdata(mem_resp_rdata),
    .sel(sel), .busy(busy)
  );

  typedef struct {
    logic        rst, r0v, r1v, mrdy, mrv;
    logic [31:0] a0, mrdata;
    logic        e_mval, e_r0rdy, e_r1rdy, e_resp0, e_resp1, e_sel, e_busy;
    logic [31:0] e_addr;
  } vec_t;

  localparam logic [31:0] WD0 = 32'hAAAA0000;
  localparam logic [31:0] WD1 = 32'hBBBB1111;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, r0v, r1v, mrdy, mrv,
                              input logic [31:0] a0, mrdata,
                              input logic mv, r0r, r1r, rs0, rs1, s, b,
                              input logic [31:0] ea);
    vec_t v;
    v.rst = rst; v.r0v = r0v; v.r1v = r1v; v.mrdy = mrdy; v.mrv = mrv;
    v.a0 = a0; v.mrdata = mrdata;
    v.e_mval = mv; v.e_r0rdy = r0r; v.e_r1rdy = r1r;
    v.e_resp0 = rs0; v.e_resp1 = rs1; v.e_sel = s; v.e_busy = b; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_val = 0; req1_val = 0; mem_req_rdy = 0; mem_resp_val = 0; mem_resp_rdata = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    req0_addr = 32'h100; req0_wen = 1'b0; req0_wdata = WD0;
    req1_addr = 32'h20;  req1_wen = 1'b1; req1_wdata = WD1;

    //            rst r0 r1 rdy rv a0      rdata        | mv r0r r1r rs0 rs1 sel busy addr
    // idle after reset
    repeat (3) vecs.push_back(mk(0,0,0,0,0, 32'h100, 0,            0,0,0,0,0,0,0, 32'h100));
    // single read from req0, response two cycles after accept
    vecs.push_back(mk(0,1,0,1,0, 32'h100, 0,            1,1,0,0,0,0,0, 32'h100));
    vecs.push_back(mk(0,0,0,1,0, 32'h100, 0,            0,0,0,0,0,0,1, 32'h100));
    vecs.push_back(mk(0,0,0,0,1, 32'h100, 32'hDEADBEEF, 0,0,0,1,0,0,1, 32'h100));
    vecs.push_back(mk(0,0,0,0,0, 32'h10,  0,            0,0,0,0,0,1,0, 32'h20));
    // reset back to prio 0
    vecs.push_back(mk(1,0,0,0,0, 32'h10,  0,            0,0,0,0,0,1,0, 32'h20));
    // both valid: grants alternate 0,1,0,1,0,1
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0,1,1,1,0, 32'h10, 0,                  1,1,0,0,0,0,0, 32'h10));
      vecs.push_back(mk(0,1,1,1,1, 32'h10, 32'h1000_0000 + k,  0,0,0,1,0,0,1, 32'h10));
      vecs.push_back(mk(0,1,1,1,0, 32'h10, 0,                  1,0,1,0,0,1,0, 32'h20));
      vecs.push_back(mk(0,1,1,1,1, 32'h10, 32'h2000_0000 + k,  0,0,0,0,1,1,1, 32'h20));
    end
    // req1 stalls in HOLD; req0 arrives but cannot steal; stray response in HOLD ignored
    vecs.push_back(mk(0,0,1,0,0, 32'h10, 0,            1,0,0,0,0,1,0, 32'h20));
    vecs.push_back(mk(0,1,1,0,0, 32'h10, 0,            1,0,0,0,0,1,1, 32'h20));
    vecs.push_back(mk(0,1,1,0,1, 32'h10, 32'h5555AAAA, 1,0,0,0,0,1,1, 32'h20));
    vecs.push_back(mk(0,1,1,1,0, 32'h10, 0,            1,0,1,0,0,1,1, 32'h20));
    vecs.push_back(mk(0,1,0,1,0, 32'h10, 0,            0,0,0,0,0,1,1, 32'h20));
    vecs.push_back(mk(0,1,0,1,1, 32'h10, 32'h0BADF00D, 0,0,0,0,1,1,1, 32'h20));
    vecs.push_back(mk(0,1,0,1,0, 32'h10, 0,            1,1,0,0,0,0,0, 32'h10));
    vecs.push_back(mk(0,0,0,0,1, 32'h10, 32'h13579BDF, 0,0,0,1,0,0,1, 32'h10));
    // stray response in IDLE ignored; sel shows prio=1
    vecs.push_back(mk(0,0,0,0,1, 32'h10, 32'h2468ACE0, 0,0,0,0,0,1,0, 32'h20));

    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; req0_val = vecs[i].r0v; req1_val = vecs[i].r1v;
      mem_req_rdy = vecs[i].mrdy; mem_resp_val = vecs[i].mrv;
      mem_resp_rdata = vecs[i].mrdata; req0_addr = vecs[i].a0;
      #1;
      chk($sformatf("v%0d_mem_req_val", i), 32'(mem_req_val), 32'(vecs[i].e_mval));
      chk($sformatf("v%0d_req0_rdy", i),    32'(req0_rdy),    32'(vecs[i].e_r0rdy));
      chk($sformatf("v%0d_req1_rdy", i),    32'(req1_rdy),    32'(vecs[i].e_r1rdy));
      chk($sformatf("v%0d_resp0_val", i),   32'(resp0_val),   32'(vecs[i].e_resp0));
      chk($sformatf("v%0d_resp1_val", i),   32'(resp1_val),   32'(vecs[i].e_resp1));
      chk($sformatf("v%0d_sel", i),         32'(sel),         32'(vecs[i].e_sel));
      chk($sformatf("v%0d_busy", i),        32'(busy),        32'(vecs[i].e_busy));
      chk($sformatf("v%0d_mem_req_addr", i), mem_req_addr,    vecs[i].e_addr);
      chk($sformatf("v%0d_mem_req_wen", i), 32'(mem_req_wen), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d_mem_req_wdata", i), mem_req_wdata, vecs[i].e_sel ? WD1 : WD0);
      chk($sformatf("v%0d_resp0_rdata", i), resp0_rdata,      vecs[i].mrdata);
      chk($sformatf("v%0d_resp1_rdata", i), resp1_rdata,      vecs[i].mrdata);
    end

    // write from req1
    @(negedge clk);
    reset = 0; idle_inputs();
    req1_val = 1; req1_addr = 32'h40; req1_wdata = 32'h12345678; mem_req_rdy = 1;
    #1;
    chk("wr_req1_rdy",   32'(req1_rdy),    32'd1);
    chk("wr_req0_rdy",   32'(req0_rdy),    32'd0);
    chk("wr_addr",       mem_req_addr,     32'h40);
    chk("wr_wen",        32'(mem_req_wen), 32'd1);
    chk("wr_wdata",      mem_req_wdata,    32'h12345678);
    @(negedge clk);
    req1_val = 0; #1;
    chk("wr_wait_resp1", 32'(resp1_val),   32'd0);
    chk("wr_wait_busy",  32'(busy),        32'd1);
    @(negedge clk);
    mem_resp_val = 1; mem_resp_rdata = 32'hCAFEF00D; #1;
    chk("wr_resp1_val",  32'(resp1_val),   32'd1);
    chk("wr_resp0_val",  32'(resp0_val),   32'd0);

    // reset while in WAIT, then a stray late response
    @(negedge clk);
    idle_inputs(); req0_val = 1; req0_addr = 32'h200; mem_req_rdy = 1; #1;
    chk("rst_first_req0_rdy", 32'(req0_rdy), 32'd1);
    @(negedge clk);
    req0_val = 0; reset = 1; #1;
    chk("rst_in_wait_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 0; mem_resp_val = 1; mem_resp_rdata = 32'h77777777; #1;
    chk("rst_stray_resp0", 32'(resp0_val), 32'd0);
    chk("rst_stray_resp1", 32'(resp1_val), 32'd0);
    chk("rst_busy",        32'(busy),      32'd0);
    chk("rst_sel_prio",    32'(sel),       32'd0);
    @(negedge clk);
    mem_resp_val = 0; req0_val = 1; #1;
    chk("rst_new_req0_rdy", 32'(req0_rdy),    32'd1);
    chk("rst_new_mem_val",  32'(mem_req_val), 32'd1);
    chk("rst_new_addr",     mem_req_addr,     32'h200);
    @(negedge clk);
    req0_val = 0; mem_resp_val = 1; mem_resp_rdata = 32'h0F0F0F0F; #1;
    chk("rst_new_resp0", 32'(resp0_val), 32'd1);
    chk("rst_new_resp1", 32'(resp1_val), 32'd0);
    @(negedge clk);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter that shares the processor's single memory port between the instruction-fetch path (requester 0) and the data-access path (requester 1). It sequences one outstanding transaction at a time. It drives the select of the internal 2:1 address/write-data muxes (Mux2_RTL instances), and it steers the memory response back to the requester that owns the transaction. It sits between the fetch/memory stages of the TinyRV1 datapath and the memory interface.

## Interface
- p_addr_nbits, 32, width of request address
- p_data_nbits, 32, width of write and read data
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_val / req1_val  input  1  requester N has a valid request
- req0_rdy / req1_rdy  output  1  request N accepted this cycle
- req0_addr / req1_addr  input  p_addr_nbits  request address
- req0_wen / req1_wen  input  1  1 = write, 0 = read
- req0_wdata / req1_wdata  input  p_data_nbits  write data
- resp0_val / resp1_val  output  1  response for requester N valid this cycle
- resp0_rdata / resp1_rdata  output  p_data_nbits  read data; equals mem_resp_rdata on both ports
- mem_req_val  output  1  request presented to memory
- mem_req_rdy  input  1  memory accepts request
- mem_req_addr / mem_req_wen / mem_req_wdata  output  as above  muxed request payload
- mem_resp_val  input  1  memory response valid
- mem_resp_rdata  input  p_data_nbits  memory read data
- sel  output  1  current grant index; drives the mux selects (0 = req0, 1 = req1)
- busy  output  1  1 while in HOLD or WAIT

## Operation
- State registers: 2-bit FSM {IDLE, HOLD, WAIT}, 1-bit owner, 1-bit prio (requester favoured on a tie).
- Grant in IDLE is combinational:
  - only one requester is valid: that requester.
  - both are valid: prio.
  - neither is valid: prio.
- Grant in HOLD/WAIT is owner. sel = grant.
- mem_req_addr/wen/wdata = payload of requester sel, in every state.
- mem_req_val = (IDLE and (req0_val or req1_val)) or HOLD. It is 0 in WAIT.
- reqN_rdy = mem_req_val and mem_req_rdy and (sel == N). At most one rdy is high per cycle.
- Fire = mem_req_val and mem_req_rdy.
- Transitions:
  - IDLE, fire: go to WAIT. owner <= sel. prio <= ~sel.
  - IDLE, a request is valid but not fired: go to HOLD. owner <= sel. The grant is now locked.
  - IDLE, no request: stay in IDLE.
  - HOLD, fire: go to WAIT. prio <= ~owner.
  - HOLD, not fired: stay in HOLD. The other requester cannot steal the grant.
  - WAIT, mem_resp_val: respOwner_val = 1 combinationally in the same cycle. Go to IDLE.
  - WAIT, otherwise: stay in WAIT.
- Requesters must hold val and payload stable from assertion until rdy. Dropping val in HOLD is illegal and the behaviour is undefined.
- mem_resp_val in IDLE or HOLD is ignored: no resp_val is raised.
- Reset, including mid-transaction: state <= IDLE, owner <= 0, prio <= 0. Any in-flight transaction is abandoned and its late response is ignored.
- Reset output values, the cycle after reset with all inputs 0: mem_req_val=0, req0_rdy=req1_rdy=0, resp0_val=resp1_val=0, sel=0, busy=0.

## Timing
- Accept-to-response: response appears in the same cycle as mem_resp_val. The memory must respond at least 1 cycle after fire.
- Earliest next accept is the cycle after the response. Peak throughput is 1 transaction per 2 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1... starting from prio.
- A requester waits at most one other transaction plus its own memory stall before it is granted.
- All outputs are derived from registered state plus current-cycle inputs. There are no combinational loops through mem_req_rdy to any val.

## Test plan
- Reset, then both val=0 for 3 cycles. Required: mem_req_val=0, sel=0, busy=0, no rdy and no resp.
- req0_val=1, addr=0x100, wen=0; mem_req_rdy=1. Required: req0_rdy=1 in cycle 0 and mem_req_addr=0x100. Memory responds in cycle 2 with 0xDEADBEEF. Required: resp0_val=1 with rdata=0xDEADBEEF in cycle 2, resp1_val=0, and prio=1 afterwards.
- Both requesters held valid (addr 0x10 and 0x20), mem_req_rdy=1, each response 1 cycle after fire, 6 transactions. Required: grants go 0,1,0,1,0,1, and mem_req_addr alternates 0x10/0x20.
- req1_val=1 with mem_req_rdy=0 for 3 cycles. req0_val rises in cycle 1. Required: FSM sits in HOLD with sel=1, req0_rdy=0 throughout, and req1 fires when rdy rises.
- Write from req1 (addr 0x40, wdata 0x12345678, wen=1). Required: mem_req_wen=1 and mem_req_wdata=0x12345678 at fire, and resp1_val pulses on mem_resp_val.
- reset asserted while in WAIT, then a stray mem_resp_val the next cycle. Required: no resp_val, state IDLE, prio=0, and a new req0 is accepted normally.
